// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  // Arbiter phases: waiting for a request, streaming one message, enforcing the idle gap
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Start + 8 data + stop bits on the line for every byte
  localparam int bits_per_byte = 10;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker starting after the last owner
module uart_rr_pick #(
  parameter int channels = 4
) (
  input  logic [channels-1:0]         req,
  input  logic [$clog2(channels)-1:0] last,
  output logic [$clog2(channels)-1:0] pick,
  output logic                        any
);

  localparam int lw = $clog2(channels);

  // One spare bit so last+k never overflows before the wrap subtraction
  logic [lw:0] sum;

  // Walk last+1, last+2, ... with wrap; the first requester found wins
  always_comb begin
    pick = '0;
    any  = 1'b0;
    sum  = '0;
    for (int k = 1; k <= channels; k++) begin
      sum = {1'b0, last} + (lw+1)'(k);
      if (sum >= (lw+1)'(channels)) begin
        sum = sum - (lw+1)'(channels);
      end
      if (!any && req[sum[lw-1:0]]) begin
        pick = sum[lw-1:0];
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter in front of a shared UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int channels   = 4,
  parameter int gap_clocks = 16,
  parameter int burst_max  = 64
) (
  input  logic                  _clock,
  input  logic                  _reset,
  input  logic [channels*8-1:0] _req_data,
  input  logic [channels-1:0]   _req_valid,
  input  logic [channels-1:0]   _req_last,
  output logic [channels-1:0]   _req_ready,
  output logic [7:0]            _tx_in,
  output logic                  _tx_valid,
  input  logic                  _tx_ready,
  output logic [channels-1:0]   _grant,
  output logic                  _busy
);

  localparam int ow = $clog2(channels);
  localparam int cw = $clog2(burst_max + 1);
  localparam int gw = ($clog2(gap_clocks + 1) > 1) ? $clog2(gap_clocks + 1) : 1;

  // Gap counter runs gap_clocks-1 down to 0, so GAP lasts exactly gap_clocks cycles
  localparam logic [gw-1:0] gap_load = gw'((gap_clocks > 0) ? gap_clocks - 1 : 0);
  localparam logic [cw-1:0] burst_end = cw'(burst_max - 1);

  arb_state_t    state, state_n;
  logic [ow-1:0] owner, owner_n;
  logic [ow-1:0] last_owner, last_owner_n;
  logic [cw-1:0] count, count_n;
  logic [gw-1:0] gap, gap_n;

  logic [ow-1:0] pick;
  logic          any;
  logic          xfer;
  logic          release_now;

  uart_rr_pick #(
    .channels(channels)
  ) u_pick (
    .req (_req_valid),
    .last(last_owner),
    .pick(pick),
    .any (any)
  );

  // State and counters; reset leaves channel 0 as the first in line
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= ow'(channels - 1);
      count      <= '0;
      gap        <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      count      <= count_n;
      gap        <= gap_n;
    end
  end

  // Next state plus the owner-to-transmitter mux; handshake passes straight through while in SEND
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    count_n      = count;
    gap_n        = gap;
    _tx_valid    = 1'b0;
    _tx_in       = 8'h00;
    _req_ready   = '0;
    _grant       = '0;
    xfer         = 1'b0;
    release_now  = 1'b0;

    case (state)
      IDLE: begin
        if (any) begin
          owner_n      = pick;
          last_owner_n = pick;
          count_n      = '0;
          state_n      = SEND;
        end
      end

      SEND: begin
        _grant[owner]      = 1'b1;
        _tx_valid          = _req_valid[owner];
        _tx_in             = _tx_valid ? _req_data[{owner, 3'b000} +: 8] : 8'h00;
        _req_ready[owner]  = _tx_ready;
        xfer               = _tx_valid && _tx_ready;
        // A silent owner keeps the grant; only a transferred byte can end the message
        if (xfer) begin
          count_n     = count + cw'(1);
          release_now = _req_last[owner] || (count == burst_end);
        end
        if (release_now) begin
          if (gap_clocks > 0) begin
            gap_n   = gap_load;
            state_n = GAP;
          end else begin
            state_n = IDLE;
          end
        end
      end

      GAP: begin
        if (gap == '0) begin
          state_n = IDLE;
        end else begin
          gap_n = gap - gw'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign _busy = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one serial transmitter (byte-in, `_tx_valid`/`_tx_ready` handshake) between several byte-stream message sources. Grants are round-robin and held for a whole message, so bytes from different sources never interleave on the line. After each message, a programmable idle gap is enforced before the next grant. The block sits between the message generators and the transmitter, replacing the direct source-to-transmitter hookup.

## Interface
- `channels`, default 4: number of requesters, 2..8.
- `gap_clocks`, default 16: idle cycles after each message release; 0 means no gap.
- `burst_max`, default 64: maximum bytes per grant; a forced release when reached, 1..255.

- `_clock`  in  1  system clock, rising edge.
- `_reset`  in  1  asynchronous, active-low reset.
- `_req_data`  in  channels*8  byte from requester i in bits [8i+7:8i].
- `_req_valid`  in  channels  requester i has a byte.
- `_req_last`  in  channels  byte on requester i is the final byte of its message.
- `_req_ready`  out  channels  byte from requester i accepted this cycle.
- `_tx_in`  out  8  byte to the transmitter.
- `_tx_valid`  out  1  `_tx_in` is valid.
- `_tx_ready`  in  1  transmitter accepts a byte.
- `_grant`  out  channels  one-hot current owner; all zero when not in SEND.
- `_busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, SEND, GAP (enum in package).
- **IDLE**
  - If any `_req_valid` bit is set, pick the first set bit searching upward from `last_owner+1` with wrap.
  - Register `owner` and `last_owner`; clear `count`; next state SEND.
  - If no bit is set, stay in IDLE.
- **SEND**
  - `_tx_valid = _req_valid[owner]`.
  - `_tx_in = _req_data[owner]`, forced to 0 when `_tx_valid` is 0.
  - `_req_ready[owner] = _tx_ready`; all other `_req_ready` bits are 0.
  - A transfer occurs when `_tx_valid && _tx_ready`. On transfer, `count` increments.
  - Release happens on a transfer with `_req_last[owner]`, or on a transfer where `count == burst_max-1`.
  - On release with `gap_clocks > 0`: load `gap = gap_clocks-1` and go to GAP.
  - On release with `gap_clocks == 0`: go to IDLE.
  - If the owner drops `_req_valid` mid-message, stay in SEND holding the grant (no timeout).
- **GAP**
  - All handshake outputs are 0.
  - `gap` decrements; at 0, next state is IDLE.
- `_req_last` is ignored when there is no transfer.
- `_req_valid` bits of non-owners are ignored while a grant is held.
- Widths:
  - `count` is `$clog2(burst_max+1)` bits.
  - `gap` is `max(1, $clog2(gap_clocks+1))` bits.
  - `owner` and `last_owner` are `$clog2(channels)` bits.
  - No counter wraps.
- **Reset** (asynchronous, any state including mid-message)
  - State IDLE, `owner=0`, `last_owner=channels-1` (channel 0 has first priority), `count=0`, `gap=0`.
  - Outputs: `_tx_valid=0`, `_tx_in=0`, `_req_ready=0`, `_grant=0`, `_busy=0`.
  - A byte half-transferred at reset is dropped; the transmitter owns its own reset.

## Timing
- Grant latency: a request seen in IDLE at edge N gives SEND and `_grant` valid after edge N. The first byte can transfer in cycle N+1.
- `_tx_valid`, `_tx_in` and `_req_ready` are combinational from the owner's inputs and `_tx_ready` while in SEND. This adds no loop, because the transmitter's ready does not depend on valid.
- Last-byte transfer at cycle M:
  - With `gap_clocks=G>0`: GAP occupies cycles M+1..M+G, IDLE arbitration at M+G+1, and the next first byte at M+G+2 earliest.
  - With `G=0`: IDLE at M+1, next byte at M+2.
- Throughput within a message is limited only by `_tx_ready`, at one byte per accepted cycle.
- Round-robin fairness: with all channels continuously requesting, grants rotate 0,1,2,3,0…
- Simultaneous new requests at release do not shorten the gap.

## Structure
- `uart_pkg`: `arb_state_t` enum (IDLE/SEND/GAP) and `bits_per_byte = 10`. The testbench also uses `bits_per_byte` for line-time checks.
- Sub-module `uart_rr_pick`: combinational round-robin picker.
  - Parameter `channels`.
  - Inputs `req[channels]` and `last[$clog2(channels)]`.
  - Outputs `pick` index and `any`.
- Everything else lives in `uart_tx_arbiter`: one `always_ff` for state/counters, plus `always_comb` next-state and output logic.

## Test plan
- **Single message.** Channel 2 sends "ping\n" (0x70 0x69 0x6E 0x67 0x0A) with `last` on 0x0A; `_tx_ready` is always 1.
  - `_grant=0100` one cycle after request.
  - 5 consecutive transfers, then GAP for 16 cycles, then IDLE.
- **Round-robin.** All 4 channels send 2-byte messages continuously; the transmitter is the real UART transmitter with `clocks_per_bit=9`.
  - Grant order 0,1,2,3,0; bytes never interleave.
  - The looped-back receiver output matches per-source sequences.
- **Burst limit.** `burst_max=4`; channel 1 sends 10 bytes with `last` only on byte 10.
  - Release after bytes 4 and 8.
  - Channel 1 is re-granted only if no other channel requests; with channel 3 requesting, channel 3 goes next.
- **Owner stall.** Channel 0 drops valid for 20 cycles mid-message while channel 1 requests.
  - Grant stays on 0; `_tx_valid=0` during the stall; no channel-1 byte appears.
- **Backpressure and zero gap.** `gap_clocks=0`; `_tx_ready` toggles every 3 cycles.
  - Every transfer coincides with ready.
  - IDLE is reached exactly 1 cycle after the last byte; next grant 1 cycle later.
- **Reset mid-message.** Assert `_reset=0` during byte 3 of 5.
  - All outputs are 0 immediately (asynchronous).
  - After release, the first grant goes to the lowest requesting channel (channel 0 priority).
